mole_round_controller: RTL and testbench
========================================

// Module: mole_round_controller
// PURPOSE
//  Game sequencer around mole_generator. Samples one mole (type + digit), shows it for a level-dependent window,
//  and judges the player's whack. Updates score, lives and level, and drives the level input back into the
//  generator. Sits between button debouncers, the generator and the 7-seg display mux.
// PARAMETERS
//  SHOW_BASE_TICKS  40  show window at level 1, in tick periods
//  SHOW_STEP        4   window reduction per level above 1
//  SHOW_MIN_TICKS   8   floor on the show window
//  GAP_TICKS        10  blank time between moles, in ticks
//  HITS_PER_LEVEL   10  scoring hits needed to advance one level
//  START_LIVES      3   lives loaded at game start (1..3)
// PORTS
//  clk            in   1   system clock
//  restart_n      in   1   asynchronous active-low reset
//  tick           in   1   1-cycle timebase strobe (for example 10 ms)
//  start          in   1   1-cycle pulse that starts a game from IDLE or GAME_OVER
//  btn            in   4   debounced 1-cycle press pulses; bit i = digit i
//  gen_type       in   3   mole_generator type: 0 plague, 1 normal, 2 royal, 3 chief, 6 error
//  gen_anode      in   4   mole_generator digit select, active-low one-hot
//  level          out  4   current level 1..8, fed to mole_generator
//  mole_visible   out  1   high while a mole is shown
//  mole_anode     out  4   latched digit, active-low; 4'b1111 when not visible
//  mole_type      out  3   latched type; valid while mole_visible
//  score          out  14  binary score, saturates at 9999
//  lives          out  2   remaining lives
//  hit_pulse      out  1   1-cycle pulse on a scoring whack
//  miss_pulse     out  1   1-cycle pulse on any life loss
//  game_over      out  1   high in GAME_OVER
// BEHAVIOUR
//  Reset values: state IDLE, level 1, score 0, lives START_LIVES, mole_visible 0, mole_anode 4'b1111,
//   mole_type 0, all pulses 0, game_over 0, timers 0.
//  FSM: IDLE -> SPAWN -> SHOW -> JUDGE -> GAP -> SPAWN ...; GAME_OVER.
//   IDLE/GAME_OVER + start: clear score, load lives, set level 1, go to SPAWN on the next cycle.
//   SPAWN (1 cycle): latch gen_type/gen_anode. gen_type==6 or gen_anode not one-hot: stay in SPAWN and resample
//    next cycle. Otherwise load the window timer and go to SHOW. mole_visible rises 1 cycle after SPAWN.
//   SHOW: timer decrements on tick. Window W = max(SHOW_MIN_TICKS, SHOW_BASE_TICKS - (level-1)*SHOW_STEP).
//    A valid whack is btn one-hot and equal to ~mole_anode; it ends SHOW immediately.
//    A wrong-digit press or a multi-bit btn is ignored.
//    Timeout: the timer reaches 0 on a tick. If a valid whack arrives in that same cycle, the whack wins.
//   JUDGE (1 cycle), outcomes:
//    whack on normal  -> +1,   hit_pulse
//    whack on royal   -> +2,   hit_pulse
//    whack on chief   -> +5,   hit_pulse
//    whack on plague  -> lives-1, miss_pulse
//    timeout on plague -> no change
//    timeout on any other type -> lives-1, miss_pulse
//   Score add saturates at 9999. After a scoring hit, if hits_in_level reaches HITS_PER_LEVEL, then
//    level+1 (saturates at 8) and hits_in_level clears.
//   Life loss leaving 0 lives -> GAME_OVER; otherwise GAP.
//   GAP: mole_visible=0 and mole_anode=4'b1111 for GAP_TICKS ticks, then SPAWN.
//  start is ignored outside IDLE/GAME_OVER. Ticks during SPAWN/JUDGE are dropped.
//  Async reset mid-game returns everything to reset values immediately; no partial scoring.
// CONFIGURATION
//  STREAK_BONUS_EN defined: a 3-bit streak counter counts consecutive scoring hits. From the 5th consecutive
//   hit onward, points are doubled (before saturation). Any life loss or plague timeout clears the streak.
//  Undefined: no streak logic, and points are exactly as listed above.
// STRUCTURE
//  mole_pkg: FSM state encodings, mole type constants (PLAGUE=0, NORMAL=1, ROYAL=2, CHIEF=3, ERR=6),
//   point values, SCORE_MAX=9999, MAX_LEVEL=8.
//  Sub-module mole_window_timer: loadable down-counter enabled by tick, with a done flag.
//   Used for both the SHOW window and the GAP delay.
// TESTING
//  1 Reset, then start, gen_type=1, gen_anode=4'b1011. Press btn=4'b0100 on tick 3 -> score 1, hit_pulse,
//    lives 3, GAP follows.
//  2 gen_type=0 (plague), btn matches -> lives 3->2, miss_pulse, score unchanged. Then a plague timeout
//    -> no change.
//  3 Level 1 normal mole, no press: timeout after exactly 40 ticks -> lives-1. Press wrong digit
//    4'b0001 against anode 4'b1110? No: against anode 4'b0111 -> ignored.
//  4 After 10 hits level=2 and the window is 36 ticks. After 70 hits level stays 8 with a window of 12.
//    Force score 9998 and whack a chief -> score 9999.
//  5 gen_type=6 for 3 cycles, then 2 -> stays in SPAWN 3 cycles, then shows a royal. Valid whack in the
//    same cycle as the final tick -> counted as a hit.
//  6 Lives 1 with a missed normal -> game_over=1, mole_anode=4'b1111. Start -> score 0, lives 3, level 1.
//    Assert restart_n low mid-SHOW -> all reset values immediately.
//    With STREAK_BONUS_EN: the 5th consecutive normal hit adds 2.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  localparam int unsigned TYPE_W   = 3;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned LEVEL_W  = 4;
  localparam int unsigned LIVES_W  = 2;
  localparam int unsigned SCORE_W  = 14;
  localparam int unsigned PTS_W    = 5;

  localparam int unsigned SCORE_MAX = 9999;
  localparam int unsigned MAX_LEVEL = 8;

  localparam int unsigned PTS_NORMAL = 1;
  localparam int unsigned PTS_ROYAL  = 2;
  localparam int unsigned PTS_CHIEF  = 5;

  localparam logic [TYPE_W-1:0] TYPE_PLAGUE = 3'd0;
  localparam logic [TYPE_W-1:0] TYPE_NORMAL = 3'd1;
  localparam logic [TYPE_W-1:0] TYPE_ROYAL  = 3'd2;
  localparam logic [TYPE_W-1:0] TYPE_CHIEF  = 3'd3;
  localparam logic [TYPE_W-1:0] TYPE_ERR    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_SHOW  = 3'd2,
    ST_JUDGE = 3'd3,
    ST_GAP   = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  // Latched mole as sampled from the generator.
  typedef struct packed {
    logic [TYPE_W-1:0] mtype;
    logic [DIGITS-1:0] anode;
  } mole_t;

  // Base points for a whack on the given type; non-scoring types give 0.
  function automatic logic [PTS_W-1:0] type_points(input logic [TYPE_W-1:0] t);
    case (t)
      TYPE_NORMAL: return PTS_W'(PTS_NORMAL);
      TYPE_ROYAL:  return PTS_W'(PTS_ROYAL);
      TYPE_CHIEF:  return PTS_W'(PTS_CHIEF);
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/mole_window_timer.sv
// Loadable tick-driven down-counter; done_c flags the tick that brings it to zero.
module mole_window_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         restart_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] count_q;

  // Load has priority, so a tick in the load cycle is dropped.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_c = en && (count_q <= W'(1));

endmodule

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: spawns, shows and judges moles, keeps score/lives/level.
// Optional feature: define STREAK_BONUS_EN to double points from the 5th consecutive hit.
module mole_round_controller
  import mole_pkg::*;
#(
  parameter int unsigned SHOW_BASE_TICKS = 40,
  parameter int unsigned SHOW_STEP       = 4,
  parameter int unsigned SHOW_MIN_TICKS  = 8,
  parameter int unsigned GAP_TICKS       = 10,
  parameter int unsigned HITS_PER_LEVEL  = 10,
  parameter int unsigned START_LIVES     = 3
) (
  input  logic               clk,
  input  logic               restart_n,
  input  logic               tick,
  input  logic               start,
  input  logic [DIGITS-1:0]  btn,
  input  logic [TYPE_W-1:0]  gen_type,
  input  logic [DIGITS-1:0]  gen_anode,
  output logic [LEVEL_W-1:0] level,
  output logic               mole_visible,
  output logic [DIGITS-1:0]  mole_anode,
  output logic [TYPE_W-1:0]  mole_type,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over
);

  localparam int unsigned TMAX    = (SHOW_BASE_TICKS > GAP_TICKS) ? SHOW_BASE_TICKS : GAP_TICKS;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);
  localparam int unsigned HITS_W  = $clog2(HITS_PER_LEVEL + 1);
  localparam int unsigned SUM_W   = SCORE_W + 1;

  state_t               state_q, state_d;
  mole_t                mole_q;
  logic                 whacked_q;
  logic [HITS_W-1:0]    hits_q;

  logic                 timer_load_c, timer_en_c, timer_done_c;
  logic [TIMER_W-1:0]   timer_val_c, window_c;
  logic [31:0]          reduce_c;
  logic                 game_start_c, spawn_ok_c, whack_c, show_end_c;
  logic                 judge_c, score_hit_c, life_loss_c;
  logic [PTS_W-1:0]     pts_c;
  logic [SUM_W-1:0]     sum_c;

`ifdef STREAK_BONUS_EN
  logic [2:0]           streak_q, streak_next_c;
`endif

  assign mole_anode = mole_q.anode;
  assign mole_type  = mole_q.mtype;

  assign timer_en_c = tick && ((state_q == ST_SHOW) || (state_q == ST_GAP));

  mole_window_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .restart_n(restart_n),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .en       (timer_en_c),
    .done_c   (timer_done_c)
  );

  // Show window for the current level, floored at SHOW_MIN_TICKS.
  always_comb begin
    reduce_c = (32'(level) - 32'd1) * SHOW_STEP;
    if (SHOW_BASE_TICKS >= reduce_c + SHOW_MIN_TICKS) begin
      window_c = TIMER_W'(SHOW_BASE_TICKS - reduce_c);
    end else begin
      window_c = TIMER_W'(SHOW_MIN_TICKS);
    end
  end

  // Judge outcome: loss when whacking a plague or letting any other type time out.
  assign judge_c     = (state_q == ST_JUDGE);
  assign score_hit_c = judge_c && whacked_q && (mole_q.mtype != TYPE_PLAGUE);
  assign life_loss_c = judge_c && (whacked_q == (mole_q.mtype == TYPE_PLAGUE));

  // Points for this hit and the unsaturated new score.
  always_comb begin
    pts_c = type_points(mole_q.mtype);
`ifdef STREAK_BONUS_EN
    streak_next_c = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
    if (streak_next_c >= 3'd5) begin
      pts_c = pts_c << 1;
    end
`endif
    sum_c = SUM_W'(score) + SUM_W'(pts_c);
  end

  // State register.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d      = state_q;
    timer_load_c = 1'b0;
    timer_val_c  = '0;
    game_start_c = 1'b0;
    spawn_ok_c   = 1'b0;
    whack_c      = 1'b0;
    show_end_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          game_start_c = 1'b1;
          state_d      = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        if ((gen_type != TYPE_ERR) && $onehot(~gen_anode)) begin
          spawn_ok_c   = 1'b1;
          timer_load_c = 1'b1;
          timer_val_c  = window_c;
          state_d      = ST_SHOW;
        end
      end
      ST_SHOW: begin
        whack_c = $onehot(btn) && (btn == ~mole_q.anode);
        if (whack_c || timer_done_c) begin
          show_end_c = 1'b1;
          state_d    = ST_JUDGE;
        end
      end
      ST_JUDGE: begin
        timer_load_c = 1'b1;
        timer_val_c  = TIMER_W'(GAP_TICKS);
        state_d      = (life_loss_c && (lives == LIVES_W'(1))) ? ST_OVER : ST_GAP;
      end
      ST_GAP: begin
        if (timer_done_c) begin
          state_d = ST_SPAWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Game datapath: latched mole, score, lives, level and pulses.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      mole_q       <= '{mtype: TYPE_PLAGUE, anode: '1};
      mole_visible <= 1'b0;
      whacked_q    <= 1'b0;
      hits_q       <= '0;
      level        <= LEVEL_W'(1);
      score        <= '0;
      lives        <= LIVES_W'(START_LIVES);
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      hit_pulse  <= score_hit_c;
      miss_pulse <= life_loss_c;
      game_over  <= (state_d == ST_OVER);
      if (game_start_c) begin
        score  <= '0;
        lives  <= LIVES_W'(START_LIVES);
        level  <= LEVEL_W'(1);
        hits_q <= '0;
      end
      if (spawn_ok_c) begin
        mole_visible <= 1'b1;
        mole_q       <= '{mtype: gen_type, anode: gen_anode};
      end
      if (show_end_c) begin
        mole_visible <= 1'b0;
        mole_q.anode <= '1;
        whacked_q    <= whack_c;
      end
      if (score_hit_c) begin
        score <= (sum_c > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_c[SCORE_W-1:0];
        if (hits_q == HITS_W'(HITS_PER_LEVEL - 1)) begin
          hits_q <= '0;
          if (level < LEVEL_W'(MAX_LEVEL)) begin
            level <= level + LEVEL_W'(1);
          end
        end else begin
          hits_q <= hits_q + HITS_W'(1);
        end
      end
      if (life_loss_c) begin
        lives <= lives - LIVES_W'(1);
      end
    end
  end

`ifdef STREAK_BONUS_EN
  // Consecutive-hit counter; any non-scoring judgement breaks the streak.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      streak_q <= '0;
    end else if (game_start_c || (judge_c && !score_hit_c)) begin
      streak_q <= '0;
    end else if (score_hit_c) begin
      streak_q <= streak_next_c;
    end
  end
`endif

endmodule

// File: tb/tb_mole_round_controller.sv
// Self-checking bench for mole_round_controller: table rows, hand sequences and a random game
// checked against a transaction-level model of the scoring rules.
module tb_mole_round_controller;

  logic        clk = 1'b0;
  logic        restart_n, tick, start;
  logic [3:0]  btn, gen_anode;
  logic [2:0]  gen_type;
  logic [3:0]  level, mole_anode;
  logic        mole_visible, hit_pulse, miss_pulse, game_over;
  logic [2:0]  mole_type;
  logic [13:0] score;
  logic [1:0]  lives;

  int checks = 0;
  int errors = 0;
  int expect_wait = -1;

  // Reference model state (one update per judged mole).
  int m_score, m_lives, m_level, m_hits, m_streak;

  typedef struct {
    int         typ;
    logic [3:0] anode;
    bit         whack;
    int         press;
    int         exp_score;
    int         exp_lives;
    bit         exp_hit;
    bit         exp_miss;
    bit         exp_over;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  mole_round_controller dut (
    .clk         (clk),
    .restart_n   (restart_n),
    .tick        (tick),
    .start       (start),
    .btn         (btn),
    .gen_type    (gen_type),
    .gen_anode   (gen_anode),
    .level       (level),
    .mole_visible(mole_visible),
    .mole_anode  (mole_anode),
    .mole_type   (mole_type),
    .score       (score),
    .lives       (lives),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required event never occurred", name);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [3:0] anode_of(input int d);
    logic [3:0] a;
    a = 4'b0001 << d;
    return ~a;
  endfunction

  function automatic int window_of(input int lvl);
    int w;
    w = 40 - (lvl - 1) * 4;
    return (w < 8) ? 8 : w;
  endfunction

  function automatic int pts_of(input int typ);
    case (typ)
      1: return 1;
      2: return 2;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int pts_eff(input int typ);
    int p;
    p = pts_of(typ);
`ifdef STREAK_BONUS_EN
    if (m_streak + 1 >= 5) p = p * 2;
`endif
    return p;
  endfunction

  task automatic model_start();
    m_score = 0; m_lives = 3; m_level = 1; m_hits = 0; m_streak = 0;
  endtask

  task automatic model_judge(input int typ, input bit whacked, output bit hit, output bit miss);
    hit = 1'b0;
    miss = 1'b0;
    if (whacked && typ != 0) begin
      m_score = m_score + pts_eff(typ);
      if (m_score > 9999) m_score = 9999;
      m_streak++;
      m_hits++;
      if (m_hits == 10) begin
        m_hits = 0;
        if (m_level < 8) m_level++;
      end
      hit = 1'b1;
    end else begin
      m_streak = 0;
      if (whacked || typ != 0) begin
        m_lives--;
        miss = 1'b1;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_level"}, level, 1);
    check({tag, "_score"}, score, 0);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_visible"}, mole_visible, 0);
    check({tag, "_anode"}, mole_anode, 15);
    check({tag, "_type"}, mole_type, 0);
    check({tag, "_hit"}, hit_pulse, 0);
    check({tag, "_miss"}, miss_pulse, 0);
    check({tag, "_over"}, game_over, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    model_start();
    check("start_score", score, 0);
    check("start_lives", lives, 3);
    check("start_level", level, 1);
    check("start_over", game_over, 0);
    expect_wait = 1;
  endtask

  // One mole: wait for it, tick through SHOW (optionally whacking on tick 'press'),
  // then step past JUDGE so the outcome is visible.
  task automatic do_mole(input int typ, input logic [3:0] an, input bit whack,
                         input int press, input int exp_w);
    int n;
    logic [3:0] inv, wrong;
    inv   = ~an;
    wrong = {inv[2:0], inv[3]};
    gen_type  = 3'(typ);
    gen_anode = an;
    n = 0;
    while (!mole_visible && n < 100) begin
      tick = 1'b1;
      cyc();
      n++;
    end
    tick = 1'b0;
    if (!mole_visible) begin
      fail_bound("spawn_wait");
      return;
    end
    if (expect_wait >= 0) check("spawn_wait", n, expect_wait);
    check("mole_anode", mole_anode, an);
    check("mole_type", mole_type, typ);
    n = 0;
    while (mole_visible && n < 100) begin
      tick  = 1'b1;
      start = (n == 1);
      btn   = '0;
      if (whack && (n + 1 == press)) btn = inv;
      else if (n == 4) btn = wrong;
      else if (n == 6) btn = inv | wrong;
      cyc();
      n++;
    end
    tick = 1'b0; start = 1'b0; btn = '0;
    if (mole_visible) begin
      fail_bound("show_end");
      return;
    end
    check("show_len", n, whack ? press : exp_w);
    cyc();
  endtask

  task automatic play(input int typ, input logic [3:0] an, input bit whack, input int press);
    bit eh, em;
    do_mole(typ, an, whack, press, window_of(m_level));
    model_judge(typ, whack, eh, em);
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("level", level, m_level);
    check("hit_pulse", hit_pulse, eh);
    check("miss_pulse", miss_pulse, em);
    check("game_over", game_over, (m_lives == 0));
    expect_wait = (m_lives == 0) ? -1 : 11;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required orderly finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    tbl[0] = '{1, 4'b1011, 1'b1, 3,  1, 3, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{0, 4'b1101, 1'b1, 2,  1, 2, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{0, 4'b0111, 1'b0, 0,  1, 2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2, 4'b1110, 1'b1, 1,  3, 2, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{3, 4'b0111, 1'b1, 40, 8, 2, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1, 4'b1101, 1'b0, 0,  8, 1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1, 4'b1011, 1'b0, 0,  8, 0, 1'b0, 1'b1, 1'b1};

    restart_n = 1'b0; tick = 1'b0; start = 1'b0; btn = '0;
    gen_type = 3'd1; gen_anode = 4'b1110;
    repeat (2) cyc();
    check_reset("por");
    restart_n = 1'b1;
    repeat (3) begin tick = 1'b1; btn = 4'b0001; cyc(); end
    tick = 1'b0; btn = '0;
    check("idle_visible", mole_visible, 0);
    check("idle_score", score, 0);

    // Table-driven rows at level 1.
    do_start();
    for (int i = 0; i < 7; i++) begin
      do_mole(tbl[i].typ, tbl[i].anode, tbl[i].whack, tbl[i].press, 40);
      check("tbl_score", score, tbl[i].exp_score);
      check("tbl_lives", lives, tbl[i].exp_lives);
      check("tbl_level", level, 1);
      check("tbl_hit", hit_pulse, tbl[i].exp_hit);
      check("tbl_miss", miss_pulse, tbl[i].exp_miss);
      check("tbl_over", game_over, tbl[i].exp_over);
      cyc();
      check("tbl_hit_1cyc", hit_pulse, 0);
      check("tbl_miss_1cyc", miss_pulse, 0);
      expect_wait = 11;
    end
    check("over_anode", mole_anode, 15);
    check("over_visible", mole_visible, 0);
    repeat (3) begin tick = 1'b1; cyc(); end
    tick = 1'b0;
    check("over_hold", game_over, 1);

    // Generator error type and non-one-hot anode keep SPAWN resampling.
    gen_type = 3'd6; gen_anode = 4'b1011; tick = 1'b1;
    do_start();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("err_spawn_hold", mole_visible, 0);
    end
    gen_type = 3'd2; gen_anode = 4'b0011;
    cyc();
    check("bad_anode_hold", mole_visible, 0);
    gen_anode = 4'b1110;
    cyc();
    tick = 1'b0;
    check("spawn_after_err", mole_visible, 1);
    expect_wait = 0;
    play(2, 4'b1110, 1'b1, 40);

    // Level progression and shrinking window.
    g = 0;
    while (m_level < 2 && g < 50) begin play(1, anode_of(g % 4), 1'b1, 1 + g % 3); g++; end
    check("level_two", level, 2);
    play(0, anode_of(1), 1'b0, 0);
    while (m_level < 8 && g < 200) begin
      play($urandom_range(1, 3), anode_of(g % 4), 1'b1, $urandom_range(1, window_of(m_level)));
      g++;
    end
    check("level_eight", level, 8);
    play(0, anode_of(2), 1'b0, 0);
    for (int k = 0; k < 10; k++) play(1, anode_of(k % 4), 1'b1, 1);
    check("level_sat", level, 8);

    // Drive score to exactly 9998, then saturate with a chief.
    g = 0;
    while (m_score < 9998 && g < 6000) begin
      if (m_score + pts_eff(3) <= 9998) play(3, anode_of(g % 4), 1'b1, 1);
      else if (m_score + pts_eff(2) <= 9998) play(2, anode_of(g % 4), 1'b1, 1);
      else if (m_score + pts_eff(1) <= 9998) play(1, anode_of(g % 4), 1'b1, 1);
      else play(0, anode_of(g % 4), 1'b0, 0);
      g++;
    end
    check("score_9998", score, 9998);
    play(3, anode_of(0), 1'b1, 2);
    check("score_sat", score, 9999);
    play(3, anode_of(3), 1'b1, 1);
    check("score_sat_hold", score, 9999);

    // Asynchronous reset in the middle of SHOW.
    gen_type = 3'd1; gen_anode = 4'b1101;
    g = 0;
    while (!mole_visible && g < 100) begin tick = 1'b1; cyc(); g++; end
    if (!mole_visible) fail_bound("pre_reset_show");
    tick = 1'b1;
    #2 restart_n = 1'b0;
    #1 check_reset("midshow");
    tick = 1'b0;
    cyc();
    restart_n = 1'b1;
    cyc();
    check("post_reset_visible", mole_visible, 0);

    do_start();
`ifdef STREAK_BONUS_EN
    for (int k = 0; k < 5; k++) play(1, anode_of(k % 4), 1'b1, 2);
    check("streak_fifth", score, 6);
`endif

    // Random game against the model, restarting after each game over.
    for (int i = 0; i < 80; i++) begin
      int typ;
      bit wh;
      typ = $urandom_range(0, 3);
      wh  = ($urandom_range(0, 9) < 7);
      play(typ, anode_of($urandom_range(0, 3)), wh, $urandom_range(1, window_of(m_level)));
      if (m_lives == 0) do_start();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
